// File: rtl/dtpu_ctrl_slave_pkg.sv
// Shared definitions for the DTPU control slave: register word offsets,
// CTRL bit positions, AXI response codes and the CTRL read-word packer.
package dtpu_ctrl_slave_pkg;

   // Word offsets, i.e. address bits [5:2]
   localparam logic [3:0] A_CTRL = 4'h0;
   localparam logic [3:0] A_GIE  = 4'h1;
   localparam logic [3:0] A_IER  = 4'h2;
   localparam logic [3:0] A_ISR  = 4'h3;

   localparam int CTRL_START = 0;
   localparam int CTRL_DONE  = 1;
   localparam int CTRL_IDLE  = 2;
   localparam int CTRL_READY = 3;
   localparam int CTRL_CONT  = 4;
   localparam int CTRL_AUTO  = 7;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef struct packed {
      logic start;
      logic done;
      logic idle;
      logic ready;
      logic auto_restart;
   } ctrl_t;

   function automatic logic [31:0] ctrl_word(input ctrl_t c);
      logic [31:0] w;
      w             = '0;
      w[CTRL_START] = c.start;
      w[CTRL_DONE]  = c.done;
      w[CTRL_IDLE]  = c.idle;
      w[CTRL_READY] = c.ready;
      w[CTRL_AUTO]  = c.auto_restart;
      return w;
   endfunction

endpackage

// File: rtl/dtpu_ctrl_regs.sv
// Register file for the DTPU control slave: start/auto-restart, sticky
// done/ready, idle sample, GIE/IER/ISR and the registered interrupt.
import dtpu_ctrl_slave_pkg::*;

module dtpu_ctrl_regs (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [7:0]  wr_data,
   input  logic        rd_en,
   input  logic [3:0]  rd_addr,
   output logic [31:0] rd_data,
   input  logic        cs_ready,
   input  logic        cs_done,
   input  logic        cs_idle,
   output logic        cs_start,
   output logic        cs_continue,
   output logic        interrupt
);

   logic       start_r, auto_r, done_r, ready_r, idle_r, cont_r, gie_r, irq_r;
   logic [1:0] ier_r, isr_r, isr_set, isr_tgl;
   logic       wr_ctrl, wr_gie, wr_ier, wr_isr, rd_ctrl;
   logic       unused_wr;

   assign wr_ctrl = wr_en && (wr_addr == A_CTRL);
   assign wr_gie  = wr_en && (wr_addr == A_GIE);
   assign wr_ier  = wr_en && (wr_addr == A_IER);
   assign wr_isr  = wr_en && (wr_addr == A_ISR);
   assign rd_ctrl = rd_en && (rd_addr == A_CTRL);

   assign isr_set = {cs_ready & ier_r[1], cs_done & ier_r[0]};
   assign isr_tgl = wr_isr ? wr_data[1:0] : 2'b00;
   assign unused_wr = ^{wr_data[6:5], wr_data[3:2]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_r <= 1'b0;
         auto_r  <= 1'b0;
         done_r  <= 1'b0;
         ready_r <= 1'b0;
         idle_r  <= 1'b0;
         cont_r  <= 1'b0;
         gie_r   <= 1'b0;
         ier_r   <= 2'b00;
         isr_r   <= 2'b00;
         irq_r   <= 1'b0;
      end else begin
         // A fresh start request outranks the accept that would clear it
         if (wr_ctrl && wr_data[CTRL_START])
            start_r <= 1'b1;
         else if (cs_ready && !auto_r)
            start_r <= 1'b0;
         if (wr_ctrl)
            auto_r <= wr_data[CTRL_AUTO];
         cont_r <= wr_ctrl && wr_data[CTRL_CONT];
         if (cs_done)
            done_r <= 1'b1;
         else if (rd_ctrl)
            done_r <= 1'b0;
         if (cs_ready)
            ready_r <= 1'b1;
         else if (rd_ctrl)
            ready_r <= 1'b0;
         idle_r <= cs_idle;
         if (wr_gie)
            gie_r <= wr_data[0];
         if (wr_ier)
            ier_r <= wr_data[1:0];
         // OR-ing the set after the toggle lets an event win over a write
         isr_r <= (isr_r ^ isr_tgl) | isr_set;
         irq_r <= gie_r && (|isr_r);
      end
   end

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         A_CTRL:  rd_data = ctrl_word('{start: start_r, done: done_r, idle: idle_r,
                                        ready: ready_r, auto_restart: auto_r});
         A_GIE:   rd_data[0]   = gie_r;
         A_IER:   rd_data[1:0] = ier_r;
         A_ISR:   rd_data[1:0] = isr_r;
         default: rd_data = '0;
      endcase
   end

   assign cs_start    = start_r;
   assign cs_continue = cont_r;
   assign interrupt   = irq_r;

endmodule

// File: rtl/dtpu_ctrl_slave.sv
// AXI4-Lite slave front end for the DTPU control port; handles the AW/W/B
// and AR/R handshakes and hands decoded accesses to dtpu_ctrl_regs.
import dtpu_ctrl_slave_pkg::*;

module dtpu_ctrl_slave #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   s_awaddr,
   input  logic                    s_awvalid,
   output logic                    s_awready,
   input  logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_wstrb,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   output logic [1:0]              s_bresp,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   input  logic [ADDR_WIDTH-1:0]   s_araddr,
   input  logic                    s_arvalid,
   output logic                    s_arready,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output logic [1:0]              s_rresp,
   output logic                    s_rvalid,
   input  logic                    s_rready,
   output logic                    cs_start,
   output logic                    cs_continue,
   input  logic                    cs_ready,
   input  logic                    cs_done,
   input  logic                    cs_idle,
   output logic                    interrupt
);

   logic        aw_held, w_held, aw_held_nx, w_held_nx, ar_en;
   logic [3:0]  aw_idx;
   logic [7:0]  w_byte;
   logic        w_lane0;
   logic        aw_hs, w_hs, b_hs, ar_hs, do_write;
   logic [31:0] rd_data;
   logic        unused_bits;

   assign aw_hs    = s_awvalid && s_awready;
   assign w_hs     = s_wvalid && s_wready;
   assign b_hs     = s_bvalid && s_bready;
   assign ar_hs    = s_arvalid && s_arready;
   assign do_write = aw_held && w_held && !s_bvalid;

   always_comb begin
      aw_held_nx = aw_held;
      w_held_nx  = w_held;
      if (b_hs) begin
         aw_held_nx = 1'b0;
         w_held_nx  = 1'b0;
      end else begin
         if (aw_hs) aw_held_nx = 1'b1;
         if (w_hs)  w_held_nx  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         s_awready <= 1'b0;
         s_wready  <= 1'b0;
         aw_idx    <= '0;
         w_byte    <= '0;
         w_lane0   <= 1'b0;
         s_bvalid  <= 1'b0;
         ar_en     <= 1'b0;
         s_rvalid  <= 1'b0;
         s_rdata   <= '0;
      end else begin
         aw_held   <= aw_held_nx;
         w_held    <= w_held_nx;
         // Readies stay low from acceptance until the B handshake retires the write
         s_awready <= !aw_held_nx;
         s_wready  <= !w_held_nx;
         if (aw_hs)
            aw_idx <= s_awaddr[5:2];
         if (w_hs) begin
            w_byte  <= s_wdata[7:0];
            w_lane0 <= s_wstrb[0];
         end
         if (do_write)
            s_bvalid <= 1'b1;
         else if (b_hs)
            s_bvalid <= 1'b0;
         ar_en <= 1'b1;
         if (ar_hs) begin
            s_rvalid <= 1'b1;
            s_rdata  <= rd_data;
         end else if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
         end
      end
   end

   assign s_arready = ar_en && !s_rvalid;
   assign s_bresp   = RESP_OKAY;
   assign s_rresp   = RESP_OKAY;

   // All registers live in byte lane 0; the rest of the word is don't-care
   assign unused_bits = ^{s_awaddr[1:0], s_araddr[1:0],
                          s_wdata[DATA_WIDTH-1:8], s_wstrb[DATA_WIDTH/8-1:1]};

   dtpu_ctrl_regs u_regs (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (do_write && w_lane0),
      .wr_addr     (aw_idx),
      .wr_data     (w_byte),
      .rd_en       (ar_hs),
      .rd_addr     (s_araddr[5:2]),
      .rd_data     (rd_data),
      .cs_ready    (cs_ready),
      .cs_done     (cs_done),
      .cs_idle     (cs_idle),
      .cs_start    (cs_start),
      .cs_continue (cs_continue),
      .interrupt   (interrupt)
   );

endmodule

// File: tb/tb_dtpu_ctrl_slave.sv
// Bench for dtpu_ctrl_slave: register-map vector table, directed handshake
// sequences, then random traffic against a register-level reference model.
module tb_dtpu_ctrl_slave;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  s_awaddr = '0;
   logic        s_awvalid = 1'b0;
   logic        s_awready;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_wvalid = 1'b0;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready = 1'b0;
   logic [5:0]  s_araddr = '0;
   logic        s_arvalid = 1'b0;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready = 1'b0;
   logic        cs_start, cs_continue, interrupt;
   logic        cs_ready = 1'b0;
   logic        cs_done = 1'b0;
   logic        cs_idle = 1'b1;

   int tests = 0;
   int fails = 0;
   int cont_cnt = 0;

   dtpu_ctrl_slave #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .cs_start(cs_start), .cs_continue(cs_continue),
      .cs_ready(cs_ready), .cs_done(cs_done), .cs_idle(cs_idle),
      .interrupt(interrupt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (cs_continue) cont_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Reference model: the register map as plain state variables
   logic       m_start, m_auto, m_done, m_ready, m_idle, m_gie;
   logic [1:0] m_ier, m_isr;

   task automatic m_reset();
      m_start = 0; m_auto = 0; m_done = 0; m_ready = 0; m_gie = 0;
      m_ier = 0; m_isr = 0; m_idle = cs_idle;
   endtask

   task automatic m_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] st);
      if (st[0]) begin
         case (a[5:2])
            4'h0: begin if (d[0]) m_start = 1; m_auto = d[7]; end
            4'h1: m_gie = d[0];
            4'h2: m_ier = d[1:0];
            4'h3: m_isr = m_isr ^ d[1:0];
            default: ;
         endcase
      end
   endtask

   task automatic m_read(input logic [5:0] a, output logic [31:0] v);
      v = 0;
      case (a[5:2])
         4'h0: begin
            v = 32'(m_start) + 32'(m_done) * 2 + 32'(m_idle) * 4 + 32'(m_ready) * 8
              + 32'(m_auto) * 128;
            m_done = 0; m_ready = 0;
         end
         4'h1: v = 32'(m_gie);
         4'h2: v = 32'(m_ier);
         4'h3: v = 32'(m_isr);
         default: v = 0;
      endcase
   endtask

   task automatic m_pulse(input bit is_done);
      if (is_done) begin
         m_done = 1;
         if (m_ier[0]) m_isr[0] = 1;
      end else begin
         m_ready = 1;
         if (m_ier[1]) m_isr[1] = 1;
         if (!m_auto) m_start = 0;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] st);
      int  n;
      logic ha, hw;
      n = 0;
      @(negedge clk);
      s_awaddr = a; s_awvalid = 1; s_wdata = d; s_wstrb = st; s_wvalid = 1; s_bready = 1;
      while ((s_awvalid || s_wvalid) && n < 40) begin
         ha = s_awvalid && s_awready;
         hw = s_wvalid && s_wready;
         @(negedge clk); n++;
         if (ha) s_awvalid = 0;
         if (hw) s_wvalid = 0;
      end
      while (!s_bvalid && n < 40) begin @(negedge clk); n++; end
      check("wr_timeout", 32'(n < 40), 1);
      check("bresp", 32'(s_bresp), 0);
      s_awvalid = 0; s_wvalid = 0;
      @(negedge clk);
      s_bready = 0;
   endtask

   task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
      int n;
      n = 0;
      @(negedge clk);
      s_araddr = a; s_arvalid = 1; s_rready = 1;
      while (!s_arready && n < 40) begin @(negedge clk); n++; end
      @(negedge clk);
      s_arvalid = 0;
      while (!s_rvalid && n < 40) begin @(negedge clk); n++; end
      check("rd_timeout", 32'(n < 40), 1);
      d = s_rdata;
      @(negedge clk);
      s_rready = 0;
   endtask

   task automatic pulse(input bit is_done);
      @(negedge clk);
      if (is_done) cs_done = 1; else cs_ready = 1;
      @(negedge clk);
      cs_done = 0; cs_ready = 0;
      @(negedge clk);
   endtask

   typedef struct {
      bit          wr;
      logic [5:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t vw(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
      vec_t v;
      v.wr = 1; v.addr = a; v.data = d; v.strb = s; v.exp = 0;
      return v;
   endfunction

   function automatic vec_t vr(input logic [5:0] a, input logic [31:0] e);
      vec_t v;
      v.wr = 0; v.addr = a; v.data = 0; v.strb = 0; v.exp = e;
      return v;
   endfunction

   logic [5:0] addrs [6] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h3C};

   initial begin
      logic [31:0] v, e;
      int          c0, bcnt, n;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_awready", 32'(s_awready), 0);
      check("rst_wready", 32'(s_wready), 0);
      check("rst_arready", 32'(s_arready), 0);
      check("rst_bvalid", 32'(s_bvalid), 0);
      check("rst_rvalid", 32'(s_rvalid), 0);
      check("rst_cs_start", 32'(cs_start), 0);
      check("rst_irq", 32'(interrupt), 0);
      reset = 1;
      axi_read(6'h00, v);
      check("rst_ctrl", v, 32'h4);
      check("rst_irq2", 32'(interrupt), 0);
      check("rst_start2", 32'(cs_start), 0);

      // Register map table
      vecs.push_back(vw(6'h04, 32'h1, 4'hF));       vecs.push_back(vr(6'h04, 32'h1));
      vecs.push_back(vw(6'h08, 32'h3, 4'h0));       vecs.push_back(vr(6'h08, 32'h0));
      vecs.push_back(vw(6'h08, 32'hFF, 4'h1));      vecs.push_back(vr(6'h08, 32'h3));
      vecs.push_back(vw(6'h08, 32'h0, 4'h1));
      vecs.push_back(vw(6'h0C, 32'h3, 4'h1));       vecs.push_back(vr(6'h0C, 32'h3));
      vecs.push_back(vw(6'h0C, 32'h1, 4'h1));       vecs.push_back(vr(6'h0C, 32'h2));
      vecs.push_back(vw(6'h0C, 32'h2, 4'h1));       vecs.push_back(vr(6'h0C, 32'h0));
      vecs.push_back(vw(6'h04, 32'h0, 4'h1));       vecs.push_back(vr(6'h04, 32'h0));
      vecs.push_back(vw(6'h06, 32'h1, 4'h1));       vecs.push_back(vr(6'h04, 32'h1));
      vecs.push_back(vw(6'h04, 32'h0, 4'h1));
      vecs.push_back(vw(6'h20, 32'hFFFFFFFF, 4'hF)); vecs.push_back(vr(6'h20, 32'h0));
      vecs.push_back(vr(6'h3C, 32'h0));
      vecs.push_back(vw(6'h00, 32'h80, 4'h1));      vecs.push_back(vr(6'h00, 32'h84));
      vecs.push_back(vw(6'h00, 32'h00, 4'h1));      vecs.push_back(vr(6'h00, 32'h04));
      vecs.push_back(vw(6'h00, 32'h80, 4'hE));      vecs.push_back(vr(6'h00, 32'h04));
      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
         end else begin
            axi_read(vecs[i].addr, v);
            check($sformatf("vec%0d_rd%0h", i, vecs[i].addr), v, vecs[i].exp);
         end
      end

      // Start held until accept
      axi_write(6'h00, 32'h1, 4'h1);
      check("start_set", 32'(cs_start), 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("start_hold", 32'(cs_start), 1);
      end
      pulse(0);
      check("start_clr", 32'(cs_start), 0);
      axi_read(6'h00, v);
      check("ready_sticky", v, 32'hC);
      axi_read(6'h00, v);
      check("ready_cor", v, 32'h4);

      // Interrupt path
      axi_write(6'h08, 32'h1, 4'h1);
      axi_write(6'h04, 32'h1, 4'h1);
      @(negedge clk); cs_done = 1;
      @(negedge clk); cs_done = 0;
      check("irq_lag", 32'(interrupt), 0);
      @(negedge clk);
      check("irq_set", 32'(interrupt), 1);
      axi_write(6'h0C, 32'h1, 4'h1);
      check("irq_clr", 32'(interrupt), 0);
      axi_read(6'h0C, v);
      check("isr_clr", v, 32'h0);
      axi_read(6'h00, v);
      check("done_sticky", v, 32'h6);

      // Auto restart
      axi_write(6'h00, 32'h81, 4'h1);
      for (int i = 0; i < 3; i++) begin
         pulse(0);
         check("auto_hold", 32'(cs_start), 1);
      end
      axi_write(6'h00, 32'h00, 4'h1);
      check("wr0_noclr", 32'(cs_start), 1);
      pulse(0);
      check("auto_off_clr", 32'(cs_start), 0);
      axi_read(6'h00, v);
      check("auto_ctrl", v, 32'hC);

      // W leads AW by 3 cycles, B stalled 4 cycles
      @(negedge clk);
      s_wdata = 32'h2; s_wstrb = 4'h1; s_wvalid = 1; s_bready = 0;
      check("w_first_rdy", 32'(s_wready), 1);
      @(negedge clk);
      s_wvalid = 0;
      for (int i = 0; i < 3; i++) begin
         check("w_held_rdy", 32'(s_wready), 0);
         @(negedge clk);
      end
      s_awaddr = 6'h08; s_awvalid = 1;
      check("aw_late_rdy", 32'(s_awready), 1);
      @(negedge clk);
      s_awvalid = 0;
      n = 0;
      while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
      check("b_wait", 32'(n < 20), 1);
      s_awaddr = 6'h08; s_awvalid = 1; s_wdata = 32'h1; s_wvalid = 1;
      bcnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (s_bvalid) bcnt++;
         check("stall_awrdy", 32'(s_awready), 0);
         check("stall_wrdy", 32'(s_wready), 0);
         @(negedge clk);
      end
      check("b_held", 32'(bcnt), 4);
      s_awvalid = 0; s_wvalid = 0; s_bready = 1;
      @(negedge clk);
      s_bready = 0;
      axi_read(6'h08, v);
      check("single_write", v, 32'h2);

      // Read in the same cycle done pulses
      @(negedge clk);
      s_araddr = 6'h00; s_arvalid = 1; s_rready = 1; cs_done = 1;
      check("cor_arrdy", 32'(s_arready), 1);
      @(negedge clk);
      s_arvalid = 0; cs_done = 0;
      check("cor_rvalid", 32'(s_rvalid), 1);
      check("cor_prev", s_rdata, 32'h4);
      @(negedge clk);
      s_rready = 0;
      axi_read(6'h00, v);
      check("cor_setwins", v, 32'h6);

      // Continue pulse
      c0 = cont_cnt;
      axi_write(6'h00, 32'h10, 4'h1);
      repeat (2) @(negedge clk);
      check("cont_once", 32'(cont_cnt - c0), 1);
      check("cont_nostart", 32'(cs_start), 0);

      // Async reset mid-transaction
      axi_write(6'h00, 32'h1, 4'h1);
      @(negedge clk);
      s_awaddr = 6'h04; s_awvalid = 1;
      @(negedge clk);
      s_awvalid = 0;
      #2 reset = 0;
      #1;
      check("arst_start", 32'(cs_start), 0);
      check("arst_awrdy", 32'(s_awready), 0);
      @(negedge clk);
      reset = 1;
      axi_read(6'h00, v);
      check("arst_ctrl", v, 32'h4);
      axi_read(6'h04, v);
      check("arst_gie", v, 32'h0);

      // Random traffic vs reference model
      m_reset();
      for (int i = 0; i < 200; i++) begin
         int          op;
         logic [5:0]  a;
         logic [31:0] d;
         logic [3:0]  st;
         op = $urandom_range(0, 9);
         a  = addrs[$urandom_range(0, 5)];
         d  = $urandom;
         st = 4'($urandom_range(0, 15));
         if (op <= 3) begin
            axi_write(a, d, st);
            m_write(a, d, st);
         end else if (op <= 6) begin
            axi_read(a, v);
            m_read(a, e);
            check($sformatf("rnd%0d_rd%0h", i, a), v, e);
         end else if (op <= 8) begin
            pulse(op == 7);
            m_pulse(op == 7);
         end else begin
            @(negedge clk);
            cs_idle = 1'($urandom_range(0, 1));
            repeat (2) @(negedge clk);
            m_idle = cs_idle;
         end
         check($sformatf("rnd%0d_start", i), 32'(cs_start), 32'(m_start));
         check($sformatf("rnd%0d_irq", i), 32'(interrupt), 32'(m_gie && (|m_isr)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
